// File: rtl/flex_pts_pkg.sv
// Shared types and constants for the flex parallel-to-serial serializer.
// Defining FLEX_PTS_PARITY_EN appends a trailing even-parity bit to every frame.
package flex_pts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_e;

`ifdef FLEX_PTS_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Counter width able to hold values up to frame_len.
  function automatic int cnt_width(input int frame_len);
    return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Reusable rollover bit counter; o_rollover_flag is high while the count sits at i_rollover_val.
// Has no FLEX_PTS_PARITY_EN dependence: the caller sizes the rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clear,
  input  logic             i_count_enable,
  input  logic [WIDTH-1:0] i_rollover_val,
  output logic             o_rollover_flag
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over counting so a fresh frame always starts from zero.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      if (r_count == i_rollover_val) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  assign o_rollover_flag = (r_count == i_rollover_val);

endmodule

// File: rtl/flex_pts_serializer.sv
// Parametrised parallel-to-serial shifter with load handshake, bit-order select and done pulse.
// Defining FLEX_PTS_PARITY_EN adds one trailing even-parity bit per frame.
//
// Handshake: a word is taken on any rising edge where load_valid && load_ready.
// load_ready is high in IDLE and, combinationally from shift_enable, on the
// last-bit strobe of a frame so a new frame can follow with no idle bit.
module flex_pts_serializer
  import flex_pts_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [NUM_BITS-1:0] parallel_in,
  input  logic                shift_enable,
  output logic                serial_out,
  output logic                busy,
  output logic                done
);

  localparam int FRAME_LEN = NUM_BITS + (PARITY_EN ? 1 : 0);
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  pts_state_e           r_state;
  pts_state_e           w_next_state;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] w_load_word;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_last;
  logic                 w_rollover;

  // The parity bit is stored in the shift register itself, on the far side
  // of the data from the output end, so it leaves right after the last data bit.
`ifdef FLEX_PTS_PARITY_EN
  logic w_parity;
  assign w_parity    = ^parallel_in;
  assign w_load_word = SHIFT_MSB ? {parallel_in, w_parity} : {w_parity, parallel_in};
`else
  assign w_load_word = parallel_in;
`endif

  assign w_shift    = (r_state == SHIFT) && shift_enable;
  assign w_last     = w_shift && w_rollover;
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  flex_counter #(
    .WIDTH(CNT_W)
  ) u_bit_counter (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_accept),
    .i_count_enable (w_shift),
    .i_rollover_val (CNT_W'(FRAME_LEN - 1)),
    .o_rollover_flag(w_rollover)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_shift <= '1;
    end else if (w_accept) begin
      r_shift <= w_load_word;
    end else if (w_shift) begin
      r_shift <= SHIFT_MSB ? {r_shift[FRAME_LEN-2:0], 1'b1}
                           : {1'b1, r_shift[FRAME_LEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_last) w_next_state = w_accept ? SHIFT : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign serial_out = (r_state == SHIFT) ? (SHIFT_MSB ? r_shift[FRAME_LEN-1] : r_shift[0])
                                         : 1'b1;
  assign busy       = (r_state == SHIFT);
  assign done       = r_done;

endmodule

// File: tb/tb_flex_pts_serializer.sv
// Scoreboard bench for flex_pts_serializer: one MSB-first and one LSB-first instance.
// Expected bit streams include the parity bit when FLEX_PTS_PARITY_EN is defined.
module tb_flex_pts_serializer;

`ifdef FLEX_PTS_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       n_rst;
  logic       se  [2];
  logic       lv  [2];
  logic [7:0] din [2];
  logic       m_ready, m_serial, m_busy, m_done;
  logic       l_ready, l_serial, l_busy, l_done;

  // Entry format: {last_bit_of_frame, serial_bit}
  logic [1:0] exp_q_m[$];
  logic [1:0] exp_q_l[$];
  bit         pend_done [2];
  bit         mon_en;
  int         n_checks;
  int         n_fail;

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_valid  (lv[0]),
    .load_ready  (m_ready),
    .parallel_in (din[0]),
    .shift_enable(se[0]),
    .serial_out  (m_serial),
    .busy        (m_busy),
    .done        (m_done)
  );

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_valid  (lv[1]),
    .load_ready  (l_ready),
    .parallel_in (din[1]),
    .shift_enable(se[1]),
    .serial_out  (l_serial),
    .busy        (l_busy),
    .done        (l_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // seq holds the data bits in transmit order, first bit at [7].
  task automatic push_frame(input int sel, input logic [7:0] seq, input logic par);
    logic [1:0] e;
    for (int i = 7; i >= 0; i--) begin
      e = {(i == 0) && (FRAME == 8), seq[i]};
      if (sel == 0) exp_q_m.push_back(e); else exp_q_l.push_back(e);
    end
    if (FRAME == 9) begin
      e = {1'b1, par};
      if (sel == 0) exp_q_m.push_back(e); else exp_q_l.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor(input int sel, input logic so, input logic bsy, input logic dn,
                         input logic rdy, input logic sen);
    logic [1:0] e;
    string      tag;
    tag = (sel == 0) ? "msb" : "lsb";
    chk({tag, "_done"}, dn, pend_done[sel]);
    pend_done[sel] = 1'b0;
    if (!bsy) begin
      chk({tag, "_idle_serial"}, so, 1'b1);
      chk({tag, "_idle_ready"}, rdy, 1'b1);
    end else if (sen) begin
      if ((sel == 0 && exp_q_m.size() == 0) || (sel == 1 && exp_q_l.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_underflow: bit shifted with nothing expected at %0t", tag, $time);
      end else begin
        e = (sel == 0) ? exp_q_m.pop_front() : exp_q_l.pop_front();
        chk({tag, "_serial_bit"}, so, e[0]);
        pend_done[sel] = e[1];
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, m_serial, m_busy, m_done, m_ready, se[0]);
      monitor(1, l_serial, l_busy, l_done, l_ready, se[1]);
    end
  end

  // ---------------- driver ----------------
  // Loads one word into an idle instance and strobes every `period` cycles.
  // With mid_pulse, offers a different word between strobes; it must be refused.
  task automatic frame(input int sel, input logic [7:0] d, input logic [7:0] seq,
                       input logic par, input int period, input bit mid_pulse);
    din[sel] = d;
    lv[sel]  = 1'b1;
    se[sel]  = 1'b0;
    @(negedge clk);
    chk("load_ready_idle", (sel == 0) ? m_ready : l_ready, 1'b1);
    push_frame(sel, seq, par);
    step();
    lv[sel] = 1'b0;
    for (int b = 0; b < FRAME; b++) begin
      for (int p = 0; p < period - 1; p++) begin
        if (mid_pulse && p == 0) begin
          lv[sel]  = 1'b1;
          din[sel] = ~d;
          @(negedge clk);
          chk("load_ready_midframe", (sel == 0) ? m_ready : l_ready, 1'b0);
        end
        step();
        lv[sel] = 1'b0;
      end
      se[sel] = 1'b1;
      step();
      se[sel] = 1'b0;
    end
    repeat (3) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    n_rst    = 1'b0;
    se[0] = 1'b0; se[1] = 1'b0;
    lv[0] = 1'b1; lv[1] = 1'b1;
    din[0] = 8'h5A; din[1] = 8'h5A;

    // Reset held two cycles with load_valid high: nothing may be captured.
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_msb_serial", m_serial, 1'b1);
    chk("rst_msb_busy", m_busy, 1'b0);
    chk("rst_msb_done", m_done, 1'b0);
    chk("rst_lsb_serial", l_serial, 1'b1);
    chk("rst_lsb_busy", l_busy, 1'b0);
    chk("rst_lsb_done", l_done, 1'b0);
    step();
    n_rst = 1'b1;
    lv[0] = 1'b0; lv[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_msb_ready", m_ready, 1'b1);
    chk("post_rst_lsb_ready", l_ready, 1'b1);
    chk("post_rst_msb_busy", m_busy, 1'b0);
    step();

    // MSB first, strobe every cycle: 0xA5 -> 1,0,1,0,0,1,0,1
    frame(0, 8'hA5, 8'b1010_0101, 1'b0, 1, 1'b0);
    // LSB first, strobe every 3rd cycle, refused mid-frame loads: 0x1E -> 0,1,1,1,1,0,0,0
    frame(1, 8'h1E, 8'b0111_1000, 1'b0, 3, 1'b1);

    // Back-to-back: 0x0F then 0xF0 offered continuously, no idle bit between.
    din[0] = 8'h0F;
    lv[0]  = 1'b1;
    @(negedge clk);
    chk("b2b_first_ready", m_ready, 1'b1);
    push_frame(0, 8'b0000_1111, 1'b0);
    step();
    din[0] = 8'hF0;
    se[0]  = 1'b1;
    for (int b = 0; b < FRAME; b++) begin
      @(negedge clk);
      chk("b2b_busy_first", m_busy, 1'b1);
      chk("b2b_ready_window", m_ready, (b == FRAME - 1) ? 1'b1 : 1'b0);
      if (b == FRAME - 1) push_frame(0, 8'b1111_0000, 1'b0);
      step();
    end
    lv[0] = 1'b0;
    for (int b = 0; b < FRAME; b++) begin
      @(negedge clk);
      chk("b2b_busy_second", m_busy, 1'b1);
      step();
    end
    se[0] = 1'b0;
    repeat (3) step();

    // Reset mid-frame after 3 shifts of 0x00: frame aborted, no done.
    din[0] = 8'h00;
    lv[0]  = 1'b1;
    @(negedge clk);
    push_frame(0, 8'h00, 1'b0);
    step();
    lv[0] = 1'b0;
    se[0] = 1'b1;
    repeat (3) step();
    se[0] = 1'b0;
    exp_q_m.delete();
    pend_done[0] = 1'b0;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    @(negedge clk);
    chk("midrst_serial", m_serial, 1'b1);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_done", m_done, 1'b0);
    repeat (2) step();

    // Parity vectors (parity 1 for 0x07, 0 for 0x03); plain data frames without the macro.
    frame(0, 8'h07, 8'b0000_0111, 1'b1, 1, 1'b0);
    frame(0, 8'h03, 8'b0000_0011, 1'b0, 2, 1'b0);
    frame(1, 8'h03, 8'b1100_0000, 1'b0, 1, 1'b0);

    chk("msb_queue_drained", 8'(exp_q_m.size()), 8'd0);
    chk("lsb_queue_drained", 8'(exp_q_l.size()), 8'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
